// File: rtl/block_sweeper_if.sv
// Plotter request channel: block position/colour plus the draw/erase req/ack pair.
// The sweeper drives the request side; the pixel plotter answers with draw_ack.
interface block_sweeper_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [2:0]     colour;
    logic           draw_req;
    logic           erase;
    logic           draw_ack;

    modport master (output x, y, colour, draw_req, erase, input draw_ack);
    modport slave  (input x, y, colour, draw_req, erase, output draw_ack);
endinterface

// File: rtl/block_sweeper.sv
// Sweeps a block of programmable cell width back and forth across the level's row,
// issuing draw/erase requests to the plotter and reporting the position on stop.
//
// state | meaning
// IDLE  | waiting for start
// DRAW  | draw request outstanding at current x
// WAIT  | block drawn, waiting for tick or stop
// ERASE | erase request outstanding at current x
// MOVE  | step x one cell, bounce at the row ends
// LOCK  | one-cycle locked pulse, position captured
module block_sweeper #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int LEVEL_W  = 6,
    parameter int SCREEN_W = 160,
    parameter int CELL     = 4,
    parameter int BASE_Y   = 120,
    parameter int WCELL_W  = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               tick_i,
    input  logic               stop_i,
    input  logic [LEVEL_W-1:0] curr_level_i,
    input  logic [WCELL_W-1:0] width_cells_i,
    input  logic [2:0]         colour_i,
    block_sweeper_if.master    plot,
    output logic               busy_o,
    output logic               locked_o,
    output logic [X_W-1:0]     lock_x_o,
    output logic [WCELL_W-1:0] lock_width_o
);
    localparam int XE_W = X_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DRAW, S_WAIT, S_ERASE, S_MOVE, S_LOCK
    } state_t;

    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [XE_W-1:0]    max_x_q, max_x_d;
    logic [WCELL_W-1:0] w_q, w_d;
    logic [2:0]         colour_q, colour_d;
    logic               dir_left_q, dir_left_d;
    logic               pend_q, pend_d;
    logic [X_W-1:0]     lock_x_q, lock_x_d;
    logic [WCELL_W-1:0] lock_w_q, lock_w_d;

    logic [WCELL_W-1:0] w_start;
    logic [XE_W-1:0]    max_start;
    logic [Y_W-1:0]     y_start;
    int                 max_int;

    always_comb begin
        w_start   = (width_cells_i == '0) ? WCELL_W'(1) : width_cells_i;
        max_int   = SCREEN_W - CELL * int'(w_start);
        max_start = (max_int < 0) ? '0 : XE_W'(max_int);
        y_start   = Y_W'(BASE_Y - CELL * (int'(curr_level_i) + 1));
    end

    // One extra bit keeps x+CELL from wrapping before the bounce compare.
    logic [XE_W-1:0] x_plus, x_minus;
    logic            x_lt_cell;

    always_comb begin
        x_plus    = {1'b0, x_q} + XE_W'(CELL);
        x_minus   = {1'b0, x_q} - XE_W'(CELL);
        x_lt_cell = {1'b0, x_q} < XE_W'(CELL);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            max_x_q    <= '0;
            w_q        <= '0;
            colour_q   <= '0;
            dir_left_q <= 1'b0;
            pend_q     <= 1'b0;
            lock_x_q   <= '0;
            lock_w_q   <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            max_x_q    <= max_x_d;
            w_q        <= w_d;
            colour_q   <= colour_d;
            dir_left_q <= dir_left_d;
            pend_q     <= pend_d;
            lock_x_q   <= lock_x_d;
            lock_w_q   <= lock_w_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        max_x_d    = max_x_q;
        w_d        = w_q;
        colour_d   = colour_q;
        dir_left_d = dir_left_q;
        pend_d     = pend_q;
        lock_x_d   = lock_x_q;
        lock_w_d   = lock_w_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_DRAW;
                    x_d        = '0;
                    dir_left_d = 1'b0;
                    y_d        = y_start;
                    w_d        = w_start;
                    max_x_d    = max_start;
                    colour_d   = colour_i;
                end
            end
            S_DRAW: begin
                if (stop_i)        pend_d  = 1'b1;
                if (plot.draw_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (stop_i || pend_q) begin
                    state_d  = S_LOCK;
                    lock_x_d = x_q;
                    lock_w_d = w_q;
                end else if (tick_i) begin
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                if (stop_i)        pend_d  = 1'b1;
                if (plot.draw_ack) state_d = S_MOVE;
            end
            S_MOVE: begin
                if (stop_i) pend_d = 1'b1;
                colour_d = colour_i;
                state_d  = S_DRAW;
                if (max_x_q == '0) begin
                    x_d = x_q;
                end else if (!dir_left_q) begin
                    if (x_plus > max_x_q) begin
                        dir_left_d = 1'b1;
                        if (!x_lt_cell) x_d = X_W'(x_minus);
                    end else begin
                        x_d = X_W'(x_plus);
                    end
                end else begin
                    if (x_lt_cell) begin
                        dir_left_d = 1'b0;
                        if (x_plus <= max_x_q) x_d = X_W'(x_plus);
                    end else begin
                        x_d = X_W'(x_minus);
                    end
                end
            end
            S_LOCK: begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign plot.x        = x_q;
    assign plot.y        = y_q;
    assign plot.draw_req = (state_q == S_DRAW) || (state_q == S_ERASE);
    assign plot.erase    = (state_q == S_ERASE);
    assign plot.colour   = (state_q == S_DRAW) ? colour_q : 3'b000;
    assign busy_o        = (state_q != S_IDLE);
    assign locked_o      = (state_q == S_LOCK);
    assign lock_x_o      = lock_x_q;
    assign lock_width_o  = lock_w_q;
endmodule

// File: tb/tb_block_sweeper.sv
// Self-checking bench for block_sweeper: sweep positions are compared against a
// closed-form triangle-wave model of the bouncing block.
module tb_block_sweeper;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int CELL = 4;

    logic clk, rst, start, tick, stop;
    logic [5:0] level;
    logic [2:0] width, col;
    logic busy, locked, busy2, locked2;
    logic [X_W-1:0] lock_x, lock_x2;
    logic [2:0] lock_w, lock_w2;
    logic ack_rand, ack_val;
    int ack_wait;
    int checks, failures;

    block_sweeper_if #(.X_W(X_W), .Y_W(Y_W)) bus ();
    block_sweeper_if #(.X_W(X_W), .Y_W(Y_W)) bus2 ();

    block_sweeper dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .tick_i(tick), .stop_i(stop),
        .curr_level_i(level), .width_cells_i(width), .colour_i(col), .plot(bus),
        .busy_o(busy), .locked_o(locked), .lock_x_o(lock_x), .lock_width_o(lock_w)
    );

    block_sweeper #(.SCREEN_W(4)) dut_small (
        .clk_i(clk), .rst_i(rst), .start_i(start), .tick_i(tick), .stop_i(stop),
        .curr_level_i(level), .width_cells_i(width), .colour_i(col), .plot(bus2),
        .busy_o(busy2), .locked_o(locked2), .lock_x_o(lock_x2), .lock_width_o(lock_w2)
    );

    assign bus2.draw_ack = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Plotter model: constant ack, or ack after a random 0..3 cycle delay.
    initial begin
        bus.draw_ack = 1'b0;
        ack_wait = 0;
        forever begin
            @(negedge clk);
            if (!ack_rand) bus.draw_ack = ack_val;
            else if (bus.draw_ack) begin
                bus.draw_ack = 1'b0;
                ack_wait = $urandom_range(0, 3);
            end else if (bus.draw_req) begin
                if (ack_wait == 0) bus.draw_ack = 1'b1;
                else ack_wait--;
            end
        end
    end

    // Position after n moves: triangle wave 0..max_x in CELL steps.
    function automatic int model_x(int n, int max_x);
        int m, p, k;
        m = max_x / CELL;
        if (m == 0) return 0;
        p = 2 * m;
        k = n % p;
        return CELL * ((k <= m) ? k : p - k);
    endfunction

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input logic [5:0] lv, input logic [2:0] w);
        level = lv; width = w; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    // Returns in the WAIT cycle following a completed draw, with the drawn values.
    task automatic wait_drawn(output logic [X_W-1:0] xd, output logic [Y_W-1:0] yd,
                              output logic [2:0] cd, output bit ok);
        bit prev;
        prev = 1'b0; ok = 1'b0; xd = '0; yd = '0; cd = '0;
        for (int i = 0; i < 200; i++) begin
            if (prev && !bus.draw_req) begin
                ok = 1'b1;
                return;
            end
            prev = bus.draw_req && !bus.erase;
            if (prev) begin xd = bus.x; yd = bus.y; cd = bus.colour; end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc(); cyc();
        checks++; if (bus.draw_req !== 1'b0) begin failures++; $display("FAIL rst_draw_req got=%0d exp=0", bus.draw_req); end
        checks++; if (busy !== 1'b0 || locked !== 1'b0) begin failures++; $display("FAIL rst_busy_locked got=%0d%0d exp=00", busy, locked); end
        checks++; if (bus.x !== 8'd0 || bus.y !== 7'd0) begin failures++; $display("FAIL rst_xy got=%0d,%0d exp=0,0", bus.x, bus.y); end
        checks++; if (lock_x !== 8'd0 || lock_w !== 3'd0) begin failures++; $display("FAIL rst_lock got=%0d,%0d exp=0,0", lock_x, lock_w); end
        rst = 1'b0; cyc();
        ack_rand = 1'b0; ack_val = 1'b0; col = 3'($urandom_range(1, 7));
        pulse_start(6'd5, 3'd2);
        checks++; if (bus.draw_req !== 1'b1 || bus.y !== 7'd96) begin failures++; $display("FAIL pre_rst_draw got=%0d,y=%0d exp=1,y=96", bus.draw_req, bus.y); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.draw_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst got=req%0d,busy%0d exp=0,0", bus.draw_req, busy); end
        checks++; if (bus.x !== 8'd0 || bus.y !== 7'd0) begin failures++; $display("FAIL midrst_xy got=%0d,%0d exp=0,0", bus.x, bus.y); end
        @(posedge clk); #1 rst = 1'b0;
        ack_val = 1'b1;
        pulse_start(6'd0, 3'd4);
        checks++; if (bus.draw_req !== 1'b1 || bus.x !== 8'd0 || bus.y !== 7'd116) begin failures++; $display("FAIL post_rst_start got=req%0d,x=%0d,y=%0d exp=1,0,116", bus.draw_req, bus.x, bus.y); end
        begin
            logic [X_W-1:0] xd; logic [Y_W-1:0] yd; logic [2:0] cd; bit ok;
            wait_drawn(xd, yd, cd, ok);
            checks++; if (!ok) begin failures++; $display("FAIL post_rst_draw timeout got=0 exp=1"); end
        end
        stop = 1'b1; cyc(); stop = 1'b0;
        checks++; if (locked !== 1'b1 || lock_x !== 8'd0 || lock_w !== 3'd4) begin failures++; $display("FAIL post_rst_lock got=%0d,%0d,%0d exp=1,0,4", locked, lock_x, lock_w); end
        cyc();
    endtask

    task automatic test_sweep_level0();
        logic [X_W-1:0] xd; logic [Y_W-1:0] yd; logic [2:0] cd; bit ok;
        ack_rand = 1'b0; ack_val = 1'b1; col = 3'($urandom_range(1, 7));
        pulse_start(6'd0, 3'd4);
        for (int n = 0; n <= 40; n++) begin
            wait_drawn(xd, yd, cd, ok);
            checks++; if (!ok) begin failures++; $display("FAIL sweep0_timeout n=%0d got=0 exp=1", n); end
            checks++; if (int'(xd) !== model_x(n, 144)) begin failures++; $display("FAIL sweep0_x n=%0d got=%0d exp=%0d", n, xd, model_x(n, 144)); end
            checks++; if (yd !== 7'd116 || cd !== col) begin failures++; $display("FAIL sweep0_y_col n=%0d got=%0d,%0d exp=116,%0d", n, yd, cd, col); end
            checks++; if (xd > 8'd144) begin failures++; $display("FAIL sweep0_bound n=%0d got=%0d exp<=144", n, xd); end
            if (n == 20) begin
                level = 6'd7; start = 1'b1; cyc(); start = 1'b0;
                checks++; if (busy !== 1'b1 || bus.draw_req !== 1'b0) begin failures++; $display("FAIL start_busy got=busy%0d,req%0d exp=1,0", busy, bus.draw_req); end
            end
            if (n < 40) begin
                repeat ($urandom_range(0, 2)) cyc();
                pulse_tick();
                if (n == 0) begin
                    checks++; if (bus.draw_req !== 1'b1 || bus.erase !== 1'b1 || bus.colour !== 3'd0) begin failures++; $display("FAIL tick_to_erase got=req%0d,er%0d,c%0d exp=1,1,0", bus.draw_req, bus.erase, bus.colour); end
                    cyc();
                    checks++; if (bus.draw_req !== 1'b0) begin failures++; $display("FAIL move_cycle got=%0d exp=0", bus.draw_req); end
                    cyc();
                    checks++; if (bus.draw_req !== 1'b1 || bus.erase !== 1'b0) begin failures++; $display("FAIL erase_to_draw got=req%0d,er%0d exp=1,0", bus.draw_req, bus.erase); end
                end
            end
        end
        stop = 1'b1; cyc(); stop = 1'b0;
        checks++; if (locked !== 1'b1 || int'(lock_x) !== model_x(40, 144) || lock_w !== 3'd4) begin failures++; $display("FAIL sweep0_lock got=%0d,%0d,%0d exp=1,%0d,4", locked, lock_x, lock_w, model_x(40, 144)); end
        cyc();
        checks++; if (busy !== 1'b0 || locked !== 1'b0) begin failures++; $display("FAIL sweep0_idle got=%0d%0d exp=00", busy, locked); end
    endtask

    task automatic test_level3_width1();
        logic [X_W-1:0] xd; logic [Y_W-1:0] yd; logic [2:0] cd; bit ok;
        ack_rand = 1'b1; col = 3'($urandom_range(1, 7));
        pulse_start(6'd3, 3'd1);
        for (int n = 0; n <= 80; n++) begin
            wait_drawn(xd, yd, cd, ok);
            checks++; if (!ok) begin failures++; $display("FAIL lvl3_timeout n=%0d got=0 exp=1", n); end
            checks++; if (int'(xd) !== model_x(n, 156) || yd !== 7'd104) begin failures++; $display("FAIL lvl3_xy n=%0d got=%0d,%0d exp=%0d,104", n, xd, yd, model_x(n, 156)); end
            if (n < 80) begin
                repeat ($urandom_range(0, 2)) cyc();
                pulse_tick();
            end
        end
        stop = 1'b1; cyc(); stop = 1'b0;
        checks++; if (locked !== 1'b1 || int'(lock_x) !== model_x(80, 156) || lock_w !== 3'd1) begin failures++; $display("FAIL lvl3_lock got=%0d,%0d,%0d exp=1,%0d,1", locked, lock_x, lock_w, model_x(80, 156)); end
        cyc(); cyc();
        ack_rand = 1'b0; ack_val = 1'b1;
    endtask

    task automatic test_width0_narrow();
        logic [X_W-1:0] xd; logic [Y_W-1:0] yd; logic [2:0] cd; bit ok;
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        ack_rand = 1'b0; ack_val = 1'b1; col = 3'($urandom_range(1, 7));
        pulse_start(6'd1, 3'd0);
        checks++; if (bus2.draw_req !== 1'b1 || bus2.x !== 8'd0 || bus2.y !== 7'd112) begin failures++; $display("FAIL w0_start got=req%0d,x=%0d,y=%0d exp=1,0,112", bus2.draw_req, bus2.x, bus2.y); end
        for (int n = 0; n < 6; n++) begin
            wait_drawn(xd, yd, cd, ok);
            checks++; if (!ok) begin failures++; $display("FAIL w0_timeout n=%0d got=0 exp=1", n); end
            repeat ($urandom_range(0, 2)) cyc();
            pulse_tick();
            checks++; if (bus2.draw_req !== 1'b1 || bus2.erase !== 1'b1) begin failures++; $display("FAIL w0_erase n=%0d got=req%0d,er%0d exp=1,1", n, bus2.draw_req, bus2.erase); end
            cyc(); cyc();
            checks++; if (bus2.draw_req !== 1'b1 || bus2.erase !== 1'b0 || bus2.x !== 8'd0) begin failures++; $display("FAIL w0_redraw n=%0d got=req%0d,er%0d,x=%0d exp=1,0,0", n, bus2.draw_req, bus2.erase, bus2.x); end
            checks++; if (int'(bus.x) !== model_x(n + 1, 156)) begin failures++; $display("FAIL w0_main_x n=%0d got=%0d exp=%0d", n, bus.x, model_x(n + 1, 156)); end
        end
        wait_drawn(xd, yd, cd, ok);
        stop = 1'b1; cyc(); stop = 1'b0;
        checks++; if (locked2 !== 1'b1 || lock_x2 !== 8'd0 || lock_w2 !== 3'd1) begin failures++; $display("FAIL w0_lock got=%0d,%0d,%0d exp=1,0,1", locked2, lock_x2, lock_w2); end
        checks++; if (lock_w !== 3'd1) begin failures++; $display("FAIL w0_main_width got=%0d exp=1", lock_w); end
        cyc();
    endtask

    task automatic test_stop_tick();
        logic [X_W-1:0] xd; logic [Y_W-1:0] yd; logic [2:0] cd; bit ok;
        logic [2:0] w, wr;
        w = 3'($urandom_range(0, 7));
        wr = (w == 3'd0) ? 3'd1 : w;
        ack_rand = 1'b0; ack_val = 1'b1;
        pulse_start(6'd2, w);
        wait_drawn(xd, yd, cd, ok);
        pulse_tick();
        wait_drawn(xd, yd, cd, ok);
        pulse_tick();
        wait_drawn(xd, yd, cd, ok);
        checks++; if (!ok || xd !== 8'd8 || yd !== 7'd108) begin failures++; $display("FAIL st_pos got=ok%0d,x=%0d,y=%0d exp=1,8,108", ok, xd, yd); end
        stop = 1'b1; tick = 1'b1; cyc(); stop = 1'b0; tick = 1'b0;
        checks++; if (bus.draw_req !== 1'b0 || locked !== 1'b1) begin failures++; $display("FAIL st_nomove got=req%0d,lk%0d exp=0,1", bus.draw_req, locked); end
        checks++; if (lock_x !== 8'd8 || lock_w !== wr) begin failures++; $display("FAIL st_lock got=%0d,%0d exp=8,%0d", lock_x, lock_w, wr); end
        cyc();
        checks++; if (busy !== 1'b0 || locked !== 1'b0 || lock_x !== 8'd8) begin failures++; $display("FAIL st_idle got=busy%0d,lk%0d,lx%0d exp=0,0,8", busy, locked, lock_x); end
    endtask

    task automatic test_stop_during_erase();
        logic [X_W-1:0] xd; logic [Y_W-1:0] yd; logic [2:0] cd; bit ok;
        ack_rand = 1'b0; ack_val = 1'b1;
        pulse_start(6'($urandom_range(0, 20)), 3'd2);
        wait_drawn(xd, yd, cd, ok);
        ack_val = 1'b0;
        pulse_tick();
        checks++; if (bus.erase !== 1'b1) begin failures++; $display("FAIL se_erase got=%0d exp=1", bus.erase); end
        stop = 1'b1; cyc(); stop = 1'b0;
        cyc();
        checks++; if (bus.erase !== 1'b1 || bus.draw_req !== 1'b1 || locked !== 1'b0) begin failures++; $display("FAIL se_held got=er%0d,req%0d,lk%0d exp=1,1,0", bus.erase, bus.draw_req, locked); end
        ack_val = 1'b1;
        wait_drawn(xd, yd, cd, ok);
        checks++; if (!ok || xd !== 8'd4) begin failures++; $display("FAIL se_redraw got=ok%0d,x=%0d exp=1,4", ok, xd); end
        cyc();
        checks++; if (locked !== 1'b1 || lock_x !== 8'd4 || lock_w !== 3'd2) begin failures++; $display("FAIL se_lock got=%0d,%0d,%0d exp=1,4,2", locked, lock_x, lock_w); end
        cyc();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL se_idle got=%0d exp=0", busy); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; tick = 1'b0; stop = 1'b0;
        level = '0; width = '0; col = '0;
        ack_rand = 1'b0; ack_val = 1'b0;
        test_reset();
        test_sweep_level0();
        test_level3_width1();
        test_width0_narrow();
        test_stop_tick();
        test_stop_during_erase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/block_sweeper.md
Name:
block_sweeper

Overview:
- Parametrised successor to the fixed-size moving-block loader for the stacker game.
- Sweeps a block of programmable width (in cells) left/right across the playfield row selected by the current level.
- Sequences draw/erase requests to the pixel plotter over a req/ack handshake.
- Locks the block position when the player presses stop, and reports the locked x and width to the stacking/scoring logic.

Parameters:
- X_W, 8, width of x coordinate
- Y_W, 7, width of y coordinate
- LEVEL_W, 6, width of level input
- SCREEN_W, 160, playfield width in pixels
- CELL, 4, cell size in pixels; also the x step per move
- BASE_Y, 120, y of the row below level 0; row y = BASE_Y - CELL*(level+1)
- WCELL_W, 3, width of block-width input

Ports:
- clk, in, 1, system clock
- reset, in, 1, asynchronous active-high reset
- start, in, 1, pulse: begin sweeping for a new level
- tick, in, 1, single-cycle move strobe (speed divider output)
- stop, in, 1, player stop request (pulse or level)
- curr_level, in, LEVEL_W, level sampled at start
- width_cells, in, WCELL_W, block width in cells, sampled at start
- colour_in, in, 3, draw colour
- draw_ack, in, 1, plotter accepted current request
- x, out, X_W, block left x
- y, out, Y_W, block top y
- colour, out, 3, plot colour (3'b000 during erase)
- draw_req, out, 1, plot request
- erase, out, 1, current request is an erase
- busy, out, 1, high in every state except IDLE
- locked, out, 1, one-cycle pulse on lock
- lock_x, out, X_W, x at lock
- lock_width, out, WCELL_W, width at lock

Behaviour:
- Reset (async, active-high) forces all outputs to 0, state IDLE, dir=right, stop_pending=0. Applies mid-handshake: draw_req drops immediately and the plotter must tolerate an abandoned request.
- States: IDLE, DRAW, WAIT, ERASE, MOVE, LOCK.
- IDLE:
  - start=1 -> x=0, dir=right, y=BASE_Y-CELL*(curr_level+1) truncated to Y_W.
  - w_r=max(width_cells,1).
  - max_x=SCREEN_W-CELL*w_r, clamped to 0 if negative.
  - Go to DRAW.
  - tick, stop and draw_ack are ignored in IDLE.
- DRAW: draw_req=1, erase=0, colour=colour_in. x, y and colour are held stable until draw_ack is sampled 1; then go to WAIT next cycle.
- WAIT:
  - draw_req=0.
  - If (stop | stop_pending): go to LOCK.
  - Else if tick: go to ERASE.
  - stop and tick in the same cycle: stop wins, no move.
- ERASE: draw_req=1, erase=1, colour=0, x unchanged. On draw_ack go to MOVE.
- MOVE: one cycle, then go to DRAW.
  - dir=right: if x+CELL>max_x, then dir=left and x=x-CELL; else x=x+CELL.
  - dir=left: if x<CELL, then dir=right and x=x+CELL; else x=x-CELL.
  - If max_x==0, x stays 0 and dir is unchanged.
- LOCK: locked=1 for one cycle; lock_x=x, lock_width=w_r (both held until the next lock or reset); clear stop_pending; go to IDLE.
- stop seen in DRAW/ERASE/MOVE sets stop_pending and is honoured at the next WAIT, so a locked block is always fully drawn.
- draw_ack outside DRAW/ERASE is ignored.
- tick outside WAIT is dropped; there is no queuing.
- start while busy is ignored.
- Latency:
  - tick in WAIT to erase draw_req: 1 cycle.
  - Erase ack to new draw_req: 2 cycles (via MOVE).
  - stop in WAIT to locked pulse: 1 cycle.
- x arithmetic is done in X_W+1 bits to avoid wrap; the result always lies within 0..max_x.

Test Plan:
- Reset mid-DRAW (draw_req=1) -> next sample: draw_req=0, x=0, y=0, busy=0; a following start operates normally.
- start with level=0, width=4, ack tied high, 40 ticks -> x=0,4,...,144 then 140,136,...; never exceeds 144; y=116 throughout.
- start with level=3, width=1 -> y=104; x reaches 156, reverses to 152; at x=0 it reverses to 4.
- width=0 and SCREEN_W=4 (max_x=0) -> width treated as 1, x stays 0 for any number of ticks, and each tick still produces an erase followed by a draw.
- stop and tick asserted together in WAIT at x=8 -> no erase, locked pulse next cycle, lock_x=8, lock_width=w_r, state returns to IDLE.
- stop pulse during ERASE with ack delayed 3 cycles -> erase completes, MOVE, redraw at new x, then lock with lock_x equal to the new x.
